// File: rtl/demux14_stream_if.sv
// Stream bundle for the 1:4 demux: one select/valid/ready input channel
// and four packed valid/ready output channels with per-port delivery counts.
interface demux14_stream_if #(
   parameter int W     = 8,
   parameter int CNT_W = 8
);
   logic               s0;
   logic               s1;
   logic               in_valid;
   logic               in_ready;
   logic [W-1:0]       in_data;
   logic [3:0]         out_valid;
   logic [3:0]         out_ready;
   logic [4*W-1:0]     out_data;
   logic [4*CNT_W-1:0] out_cnt;

   modport master (
      output s0, s1, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_cnt
   );

   modport slave (
      input  s0, s1, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_cnt
   );
endinterface

// File: rtl/demux14_stream.sv
// Registered 1:4 stream demux routed by {s0,s1}; 1-cycle latency, one holding register per port.
// Backpressure: in_ready drops only when the selected port is full and its consumer is not draining.
module demux14_stream #(
   parameter int W     = 8,
   parameter int CNT_W = 8
) (
   input logic             clk,
   input logic             rst_n,
   demux14_stream_if.slave bus
);

   logic [1:0]       sel;
   logic             in_rdy;
   logic             accept;
   logic [3:0]       vld_q;
   logic [3:0]       vld_d;
   logic [W-1:0]     data_q [4];
   logic [W-1:0]     data_d [4];
   logic [CNT_W-1:0] cnt_q  [4];
   logic [CNT_W-1:0] cnt_d  [4];

   assign sel    = {bus.s0, bus.s1};
   // A full port can still take a word in the same cycle it hands one off.
   assign in_rdy = ~vld_q[sel] | bus.out_ready[sel];
   assign accept = bus.in_valid & in_rdy;

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = vld_q;

   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      cnt_d  = cnt_q;
      for (int k = 0; k < 4; k++) begin
         if (vld_q[k] & bus.out_ready[k]) begin
            vld_d[k] = 1'b0;
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
         end
         if (accept && (sel == 2'(k))) begin
            vld_d[k]  = 1'b1;
            data_d[k] = bus.in_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int k = 0; k < 4; k++) begin
            data_q[k] <= '0;
            cnt_q[k]  <= '0;
         end
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_pack
      assign bus.out_data[g*W +: W]        = data_q[g];
      assign bus.out_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
   end

endmodule

// File: tb/tb_demux14_stream.sv
// Bench for demux14_stream: directed vector table, hand-written corner sequences,
// then random traffic compared against a per-port occupancy/counter model.
module tb_demux14_stream;
   localparam int W     = 8;
   localparam int CNT_W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   demux14_stream_if #(.W(W), .CNT_W(CNT_W)) bus ();
   demux14_stream #(.W(W), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [1:0]  sel;
      logic        vin;
      logic [7:0]  din;
      logic [3:0]  ordy;
      logic        rdy;
      logic [3:0]  vld;
      logic [31:0] data;
      logic [31:0] cnt;
   } vec_t;

   vec_t tbl [14];

   // model: words waiting per port, last word written, delivered count
   int         m_occ  [4];
   logic [7:0] m_last [4];
   int         m_cnt  [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] sel, input logic vin, input logic [7:0] din,
                        input logic [3:0] ordy);
      bus.s0        = sel[1];
      bus.s1        = sel[0];
      bus.in_valid  = vin;
      bus.in_data   = din;
      bus.out_ready = ordy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #3;
      rst_n = 1'b0;
      drive(2'd0, 1'b0, 8'h00, 4'h0);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);
      check("rst_out_data", bus.out_data, 32'h0);
      check("rst_out_cnt", bus.out_cnt, 32'h0);
      for (int s = 0; s < 4; s++) begin
         drive(2'(s), 1'b0, 8'h00, 4'h0);
         #1;
         check("rst_in_ready", 32'(bus.in_ready), 32'h1);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(2'd0, 1'b0, 8'h00, 4'h0);
      step();
   endtask

   initial begin
      logic [31:0] ed;
      logic [31:0] ec;
      logic [3:0]  ev;
      logic [1:0]  sel;
      logic        vin;
      logic [7:0]  din;
      logic [3:0]  ordy;
      logic        exp_rdy;

      // routing, port-2 backpressure, select change while port 0 is stalled
      tbl[0]  = '{2'd0, 1'b1, 8'hA0, 4'hF, 1'b1, 4'b0001, 32'h000000A0, 32'h00000000};
      tbl[1]  = '{2'd1, 1'b1, 8'hA1, 4'hF, 1'b1, 4'b0010, 32'h0000A1A0, 32'h00000001};
      tbl[2]  = '{2'd2, 1'b1, 8'hA2, 4'hF, 1'b1, 4'b0100, 32'h00A2A1A0, 32'h00000101};
      tbl[3]  = '{2'd3, 1'b1, 8'hA3, 4'hF, 1'b1, 4'b1000, 32'hA3A2A1A0, 32'h00010101};
      tbl[4]  = '{2'd0, 1'b0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'hA3A2A1A0, 32'h01010101};
      tbl[5]  = '{2'd2, 1'b1, 8'h55, 4'hB, 1'b1, 4'b0100, 32'hA355A1A0, 32'h01010101};
      tbl[6]  = '{2'd2, 1'b1, 8'h66, 4'hB, 1'b0, 4'b0100, 32'hA355A1A0, 32'h01010101};
      tbl[7]  = '{2'd1, 1'b1, 8'h77, 4'hB, 1'b1, 4'b0110, 32'hA35577A0, 32'h01010101};
      tbl[8]  = '{2'd2, 1'b1, 8'h66, 4'hF, 1'b1, 4'b0100, 32'hA36677A0, 32'h01020201};
      tbl[9]  = '{2'd0, 1'b0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'hA36677A0, 32'h01030201};
      tbl[10] = '{2'd0, 1'b1, 8'hC0, 4'hE, 1'b1, 4'b0001, 32'hA36677C0, 32'h01030201};
      tbl[11] = '{2'd0, 1'b1, 8'hC1, 4'hE, 1'b0, 4'b0001, 32'hA36677C0, 32'h01030201};
      tbl[12] = '{2'd1, 1'b1, 8'hC1, 4'hE, 1'b1, 4'b0011, 32'hA366C1C0, 32'h01030201};
      tbl[13] = '{2'd0, 1'b0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'hA366C1C0, 32'h01030302};

      drive(2'd0, 1'b0, 8'h00, 4'h0);
      do_reset();

      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].sel, tbl[i].vin, tbl[i].din, tbl[i].ordy);
         #1;
         check($sformatf("tbl%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
         step();
         check($sformatf("tbl%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].vld));
         check($sformatf("tbl%0d_out_data", i), bus.out_data, tbl[i].data);
         check($sformatf("tbl%0d_out_cnt", i), bus.out_cnt, tbl[i].cnt);
      end

      // full-rate streaming into port 3
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive(2'd3, 1'b1, 8'(i), 4'hF);
         #1;
         check("stream_in_ready", 32'(bus.in_ready), 32'h1);
         step();
         check("stream_out_valid", 32'(bus.out_valid), 32'h8);
         check("stream_data3", 32'(bus.out_data[31:24]), 32'(i));
      end
      drive(2'd0, 1'b0, 8'h00, 4'hF);
      step();
      check("stream_cnt3", 32'(bus.out_cnt[31:24]), 32'd16);

      // counter wrap on port 0
      do_reset();
      for (int i = 0; i < 256; i++) begin
         drive(2'd0, 1'b1, 8'(i), 4'hF);
         step();
      end
      check("wrap_cnt0_255", 32'(bus.out_cnt[7:0]), 32'hFF);
      drive(2'd0, 1'b0, 8'h00, 4'hF);
      step();
      check("wrap_cnt0_256", 32'(bus.out_cnt[7:0]), 32'h00);
      drive(2'd0, 1'b1, 8'h5A, 4'hF);
      step();
      drive(2'd0, 1'b0, 8'h00, 4'hF);
      step();
      check("wrap_cnt0_257", 32'(bus.out_cnt[7:0]), 32'h01);

      // fill every port, then reset with words held
      for (int i = 0; i < 4; i++) begin
         drive(2'(i), 1'b1, 8'(8'hD0 + i), 4'h0);
         step();
      end
      check("hold_out_valid", 32'(bus.out_valid), 32'hF);
      check("hold_out_data", bus.out_data, 32'hD3D2D1D0);
      do_reset();

      // random traffic against the model
      for (int k = 0; k < 4; k++) begin
         m_occ[k]  = 0;
         m_last[k] = 8'h00;
         m_cnt[k]  = 0;
      end
      for (int c = 0; c < 400; c++) begin
         sel  = 2'($urandom_range(0, 3));
         vin  = ($urandom_range(0, 3) != 0);
         din  = 8'($urandom);
         ordy = 4'($urandom);
         drive(sel, vin, din, ordy);
         #1;
         exp_rdy = (m_occ[sel] == 0) || ordy[sel];
         check("rnd_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
         step();
         for (int k = 0; k < 4; k++) begin
            if (m_occ[k] > 0 && ordy[k]) begin
               m_occ[k]--;
               m_cnt[k] = (m_cnt[k] + 1) % 256;
            end
         end
         if (vin && exp_rdy) begin
            m_occ[sel]++;
            m_last[sel] = din;
         end
         for (int k = 0; k < 4; k++) begin
            ev[k]          = (m_occ[k] > 0);
            ed[k*8 +: 8]   = m_last[k];
            ec[k*8 +: 8]   = 8'(m_cnt[k]);
         end
         check("rnd_out_valid", 32'(bus.out_valid), 32'(ev));
         check("rnd_out_data", bus.out_data, ed);
         check("rnd_out_cnt", bus.out_cnt, ec);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
